// File: rtl/ppfifo_gen_pkg.sv
// Shared constants for the ppfifo pattern generator: pattern modes, FSM encoding
// and the Galois LFSR tap masks for each supported data width.
package ppfifo_gen_pkg;

   localparam logic [1:0] MODE_COUNT = 2'd0;
   localparam logic [1:0] MODE_WALK  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Maximal-length Galois taps for a right-shifting LFSR, keyed on width.
   function automatic logic [63:0] lfsr_taps(input int width);
      case (width)
         8:       return 64'h0000_0000_0000_00B8;
         16:      return 64'h0000_0000_0000_B400;
         32:      return 64'h0000_0000_8020_0003;
         default: return 64'hD800_0000_0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/ppfifo_pattern_core.sv
// Pattern register and next-value logic for the ppfifo pattern generator.
// A zero seed is replaced by 1 only in walking-ones and LFSR modes, where zero would lock up.
import ppfifo_gen_pkg::*;

module ppfifo_pattern_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  advance,
   input  logic [1:0]            mode,
   output logic [DATA_WIDTH-1:0] pattern
);

   localparam logic [63:0]           TAPS_ALL = lfsr_taps(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] TAPS     = TAPS_ALL[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] seed_fix;
   logic [DATA_WIDTH-1:0] pattern_nxt;

   always_comb begin
      seed_fix = seed;
      if ((seed == '0) && ((mode == MODE_LFSR) || (mode == MODE_WALK))) begin
         seed_fix = ONE;
      end
   end

   always_comb begin
      pattern_nxt = pattern;
      case (mode)
         MODE_COUNT: pattern_nxt = pattern + ONE;
         MODE_WALK:  pattern_nxt = {pattern[DATA_WIDTH-2:0], pattern[DATA_WIDTH-1]};
         MODE_LFSR:  pattern_nxt = pattern[0] ? ((pattern >> 1) ^ TAPS) : (pattern >> 1);
         default:    pattern_nxt = pattern;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || load) begin
         pattern <= seed_fix;
      end else if (advance) begin
         pattern <= pattern_nxt;
      end
   end

endmodule

// File: rtl/ppfifo_pattern_generator.sv
// Ping-pong FIFO write-side source: acquires a ready channel, writes i_wr_size
// pattern words, releases it, and optionally stops after a buffer limit.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no channel held; acquire on enable + ready; reload when disabled
// ST_FILL    | channel held; one word per enabled cycle until count == size
// ST_RELEASE | one cycle: drop o_wr_act, bump buffer count, check limit
// ST_DONE    | limit reached; wait for i_enable low to rearm
import ppfifo_gen_pkg::*;

module ppfifo_pattern_generator #(
   parameter int DATA_WIDTH   = 32,
   parameter int SIZE_WIDTH   = 24,
   parameter int BCOUNT_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_enable,
   input  logic [1:0]              i_mode,
   input  logic [DATA_WIDTH-1:0]   i_seed,
   input  logic [BCOUNT_WIDTH-1:0] i_buffer_limit,
   input  logic [1:0]              i_wr_rdy,
   output logic [1:0]              o_wr_act,
   input  logic [SIZE_WIDTH-1:0]   i_wr_size,
   output logic                    o_wr_stb,
   output logic [DATA_WIDTH-1:0]   o_wr_data,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [BCOUNT_WIDTH-1:0] o_buffers_filled
);

   state_t                  state_q;
   state_t                  state_d;
   logic [1:0]              mode_q;
   logic [SIZE_WIDTH-1:0]   size_q;
   logic [SIZE_WIDTH-1:0]   count_q;
   logic [BCOUNT_WIDTH-1:0] filled_inc;
   logic                    done_hit;
   logic                    load;
   logic                    acquire;
   logic                    strobe_en;
   logic [1:0]              core_mode;
   logic [DATA_WIDTH-1:0]   pattern;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (acquire) state_d = ST_FILL;
         ST_FILL:    if (count_q == size_q) state_d = ST_RELEASE;
         ST_RELEASE: state_d = done_hit ? ST_DONE : ST_IDLE;
         ST_DONE:    if (!i_enable) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Seed reload uses the live mode; advancing uses the mode latched at acquisition.
   always_comb begin
      load       = !i_enable && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      acquire    = (state_q == ST_IDLE) && i_enable && (i_wr_rdy != 2'b00) && (o_wr_act == 2'b00);
      strobe_en  = (state_q == ST_FILL) && i_enable && (count_q < size_q);
      core_mode  = (state_q == ST_FILL) ? mode_q : i_mode;
      filled_inc = (&o_buffers_filled) ? o_buffers_filled
                                       : o_buffers_filled + BCOUNT_WIDTH'(1);
      done_hit   = (i_buffer_limit != '0) && (filled_inc == i_buffer_limit);
      o_busy     = (state_q == ST_FILL) || (state_q == ST_RELEASE);
      o_done     = (state_q == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_wr_act         <= 2'b00;
         o_wr_stb         <= 1'b0;
         o_wr_data        <= '0;
         o_buffers_filled <= '0;
         count_q          <= '0;
         size_q           <= '0;
         mode_q           <= MODE_COUNT;
      end else begin
         o_wr_stb <= strobe_en;
         if (strobe_en) begin
            o_wr_data <= pattern;
            count_q   <= count_q + SIZE_WIDTH'(1);
         end
         if (acquire) begin
            o_wr_act <= i_wr_rdy[0] ? 2'b01 : 2'b10;
            count_q  <= '0;
            mode_q   <= i_mode;
            size_q   <= i_wr_size;
         end
         if (state_q == ST_RELEASE) begin
            o_wr_act         <= 2'b00;
            o_buffers_filled <= filled_inc;
         end
         if (load) begin
            o_buffers_filled <= '0;
         end
      end
   end

   ppfifo_pattern_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .seed    (i_seed),
      .advance (strobe_en),
      .mode    (core_mode),
      .pattern (pattern)
   );

endmodule

// File: tb/tb_ppfifo_pattern_generator.sv
// Directed bench: 32-, 8- and 16-bit generators share stimulus; each test checks the relevant width.
module tb_ppfifo_pattern_generator;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  mode;
   logic [31:0] seed;
   logic [31:0] limit;
   logic [1:0]  rdy;
   logic [23:0] size;

   logic [1:0]  act32, act8, act16;
   logic        stb32, stb8, stb16;
   logic [31:0] data32;
   logic [7:0]  data8;
   logic [15:0] data16;
   logic        busy32, busy8, busy16;
   logic        done32, done8, done16;
   logic [31:0] filled32, filled8, filled16;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] q32[$];
   logic [7:0]  q8[$];
   logic [15:0] q16[$];

   ppfifo_pattern_generator #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .i_enable(enable), .i_mode(mode), .i_seed(seed),
      .i_buffer_limit(limit), .i_wr_rdy(rdy), .o_wr_act(act32), .i_wr_size(size),
      .o_wr_stb(stb32), .o_wr_data(data32), .o_busy(busy32), .o_done(done32),
      .o_buffers_filled(filled32));

   ppfifo_pattern_generator #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .i_enable(enable), .i_mode(mode), .i_seed(seed[7:0]),
      .i_buffer_limit(limit), .i_wr_rdy(rdy), .o_wr_act(act8), .i_wr_size(size),
      .o_wr_stb(stb8), .o_wr_data(data8), .o_busy(busy8), .o_done(done8),
      .o_buffers_filled(filled8));

   ppfifo_pattern_generator #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .i_enable(enable), .i_mode(mode), .i_seed(seed[15:0]),
      .i_buffer_limit(limit), .i_wr_rdy(rdy), .o_wr_act(act16), .i_wr_size(size),
      .o_wr_stb(stb16), .o_wr_data(data16), .o_busy(busy16), .o_done(done16),
      .o_buffers_filled(filled16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic setup(input logic [1:0] m, input logic [31:0] s, input logic [23:0] sz,
                        input logic [31:0] lim, input logic [1:0] r);
      enable = 1'b0;
      mode   = m;
      seed   = s;
      size   = sz;
      limit  = lim;
      rdy    = r;
      repeat (2) @(negedge clk);
   endtask

   // Follows one acquire..release of the 32-bit instance, logging strobed words of all widths.
   task automatic capture(input int pause_after, output int nstb, output logic [1:0] act_or,
                          output int gap_stb, output logic gap_act_ok);
      bit seen = 0;
      bit fin  = 0;
      nstb = 0; act_or = 2'b00; gap_stb = 0; gap_act_ok = 1'b1;
      q32.delete(); q8.delete(); q16.delete();
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         @(negedge clk);
         if (act32 != 2'b00) begin
            seen = 1;
            act_or |= act32;
         end else if (seen) begin
            fin = 1;
         end
         if (stb32) begin
            q32.push_back(data32); q8.push_back(data8); q16.push_back(data16);
            nstb++;
            if (nstb == pause_after) begin
               enable = 1'b0;
               repeat (3) begin
                  @(negedge clk);
                  if (stb32) gap_stb++;
                  if (act32 == 2'b00) gap_act_ok = 1'b0;
               end
               enable = 1'b1;
            end
         end
      end
      check("capture_complete", fin, 1);
   endtask

   initial begin
      int          nstb, gap_stb, ns;
      logic [1:0]  act_or;
      logic        gap_ok;
      logic [31:0] last;
      logic [7:0]  exp8  [3] = '{8'h80, 8'h01, 8'h02};
      logic [15:0] exp16 [3] = '{16'h0001, 16'hB400, 16'h5A00};

      rst = 1'b1; enable = 1'b0; mode = 2'd0; seed = 32'h0;
      limit = 32'd2; rdy = 2'b11; size = 24'd4;
      repeat (2) @(negedge clk);
      check("rst_act", act32, 0);
      check("rst_stb", stb32, 0);
      check("rst_data", data32, 0);
      check("rst_busy", busy32, 0);
      check("rst_done", done32, 0);
      check("rst_filled", filled32, 0);
      rst = 1'b0;

      // 1: count mode, two buffers then DONE
      setup(2'd0, 32'h0, 24'd4, 32'd2, 2'b11);
      enable = 1'b1;
      capture(0, nstb, act_or, gap_stb, gap_ok);
      check("t1_b0_act", act_or, 2'b01);
      check("t1_b0_n", nstb, 4);
      for (int i = 0; i < 4; i++) check($sformatf("t1_b0_d%0d", i), q32[i], i);
      capture(0, nstb, act_or, gap_stb, gap_ok);
      check("t1_b1_act", act_or, 2'b01);
      check("t1_b1_n", nstb, 4);
      for (int i = 0; i < 4; i++) check($sformatf("t1_b1_d%0d", i), q32[i], i + 4);
      check("t1_done", done32, 1);
      check("t1_filled", filled32, 2);
      check("t1_busy", busy32, 0);
      repeat (3) @(negedge clk);
      check("t1_no_reacq", act32, 0);
      check("t1_done_hold", done32, 1);

      // 2: only channel 1 ready, walking ones at 8 bits
      setup(2'd1, 32'h80, 24'd3, 32'd0, 2'b10);
      enable = 1'b1;
      capture(0, nstb, act_or, gap_stb, gap_ok);
      enable = 1'b0;
      check("t2_act", act_or, 2'b10);
      check("t2_n", nstb, 3);
      for (int i = 0; i < 3; i++) check($sformatf("t2_d%0d", i), q8[i], exp8[i]);

      // 3: LFSR at 16 bits, zero seed
      setup(2'd2, 32'h0, 24'd3, 32'd0, 2'b11);
      enable = 1'b1;
      capture(0, nstb, act_or, gap_stb, gap_ok);
      enable = 1'b0;
      check("t3_act", act_or, 2'b01);
      check("t3_n", nstb, 3);
      for (int i = 0; i < 3; i++) check($sformatf("t3_d%0d", i), q16[i], exp16[i]);

      // 4: enable gap after the second strobe
      setup(2'd0, 32'h0, 24'd6, 32'd0, 2'b11);
      enable = 1'b1;
      capture(2, nstb, act_or, gap_stb, gap_ok);
      enable = 1'b0;
      check("t4_n", nstb, 6);
      check("t4_gap_stb", gap_stb, 0);
      check("t4_gap_act", gap_ok, 1);
      for (int i = 0; i < 6; i++) check($sformatf("t4_d%0d", i), q32[i], i);

      // 5: zero-size buffers up to limit, then rearm
      setup(2'd0, 32'h0, 24'd0, 32'd3, 2'b11);
      enable = 1'b1;
      for (int b = 0; b < 3; b++) begin
         capture(0, nstb, act_or, gap_stb, gap_ok);
         check($sformatf("t5_b%0d_n", b), nstb, 0);
         check($sformatf("t5_b%0d_act", b), act_or, 2'b01);
      end
      check("t5_filled", filled32, 3);
      check("t5_done", done32, 1);
      enable = 1'b0;
      @(negedge clk);
      check("t5_rearm_done", done32, 0);
      check("t5_rearm_filled", filled32, 0);

      // 6: reset during the second strobe of a size-8 buffer
      setup(2'd0, 32'h10, 24'd8, 32'd0, 2'b11);
      enable = 1'b1;
      ns = 0; last = '0;
      for (int c = 0; c < 50 && ns < 2; c++) begin
         @(negedge clk);
         if (stb32) begin
            ns++;
            last = data32;
         end
      end
      check("t6_two_strobes", ns, 2);
      check("t6_second_data", last, 32'h11);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_act", act32, 0);
      check("t6_rst_stb", stb32, 0);
      check("t6_rst_data", data32, 0);
      check("t6_rst_busy", busy32, 0);
      rst = 1'b0;
      capture(0, nstb, act_or, gap_stb, gap_ok);
      enable = 1'b0;
      check("t6_n", nstb, 8);
      check("t6_first", q32[0], 32'h10);
      check("t6_last", q32[7], 32'h17);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
